mips_mc_controller: RTL

Multi-cycle MIPS control unit: a Moore state machine plus ALU decoder that sequences one instruction over 3–5 clock cycles. It sits directly upstream of the datapath blocks (enable flops, muxes, register file, ALU). It consumes the opcode/funct fields from the instruction register and the ALU zero flag. It produces every enable, mux select and ALU control code those blocks need.

---
 rtl/mips_mc_controller.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_controller.sv
// mips_mc_controller
//   Multi-cycle MIPS control unit. A Moore FSM steps one instruction through
//   3..5 states; an ALU decoder turns aluop/funct into the ALU function code.
//
//   Ports
//     clk         rising-edge clock
//     reset       asynchronous active-low reset (0 = in reset)
//     op, funct   instr[31:26] / instr[5:0] from the instruction register
//     zero        ALU zero flag, only consulted in BRANCH
//     pcen        PC enable = pcwrite | (branch & zero)
//     memwrite, iord, irwrite, regdst, memtoreg, regwrite,
//     alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]
//                 datapath enables / selects, registered
//     illegal     high during DECODE when op is not supported
//     state[3:0]  current state encoding (debug)
//
//   state   | meaning
//   --------+---------------------------------------------
//   FETCH   | read instr at PC, IR <= mem, PC <= PC + 4
//   DECODE  | read regs, precompute branch target
//   MEMADR  | ALUOut <= A + signext(imm)
//   MEMRD   | read data memory at ALUOut
//   MEMWB   | rt <= Data
//   MEMWR   | write B to data memory at ALUOut
//   EXECUTE | R-type ALU op on A, B
//   ALUWB   | rd <= ALUOut
//   BRANCH  | A - B, PC <= ALUOut if zero
//   ADDIEX  | A + signext(imm)
//   ADDIWB  | rt <= ALUOut
//   JUMP    | PC <= jump target
//   12..15  | unreachable, return to FETCH with outputs low

module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_q, state_d;
  logic       run_q, run_d;
  ctl_t       ctl_q, ctl_d;
  logic [2:0] alucontrol_q, alucontrol_d;
  logic       op_legal;

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
      default:                                        op_legal = 1'b0;
    endcase
  end

  // Next state. run_q is low for the reset period, so the first rising edge
  // after release lands in FETCH with FETCH outputs, not in DECODE.
  always_comb begin
    run_d   = 1'b1;
    state_d = FETCH;
    if (run_q) begin
      case (state_q)
        FETCH:   state_d = DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_RTYPE:     state_d = EXECUTE;
            OP_BEQ:       state_d = BRANCH;
            OP_ADDI:      state_d = ADDIEX;
            OP_J:         state_d = JUMP;
            default:      state_d = FETCH;
          endcase
        end
        MEMADR:  state_d = op[3] ? MEMWR : MEMRD;
        MEMRD:   state_d = MEMWB;
        EXECUTE: state_d = ALUWB;
        ADDIEX:  state_d = ADDIWB;
        default: state_d = FETCH;
      endcase
    end
  end

  // Outputs are decoded from the state being entered and registered, so they
  // are glitch-free and cleared together with the state by reset.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      FETCH: begin
        ctl_d.alusrcb = 2'b01;
        ctl_d.irwrite = 1'b1;
        ctl_d.pcwrite = 1'b1;
      end
      DECODE:  ctl_d.alusrcb = 2'b11;
      MEMADR, ADDIEX: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.alusrcb = 2'b10;
      end
      MEMRD:   ctl_d.iord = 1'b1;
      MEMWB: begin
        ctl_d.memtoreg = 1'b1;
        ctl_d.regwrite = 1'b1;
      end
      MEMWR: begin
        ctl_d.iord     = 1'b1;
        ctl_d.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.aluop   = 2'b10;
      end
      ALUWB: begin
        ctl_d.regdst   = 1'b1;
        ctl_d.regwrite = 1'b1;
      end
      BRANCH: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.aluop   = 2'b01;
        ctl_d.pcsrc   = 2'b01;
        ctl_d.branch  = 1'b1;
      end
      ADDIWB:  ctl_d.regwrite = 1'b1;
      JUMP: begin
        ctl_d.pcsrc   = 2'b10;
        ctl_d.pcwrite = 1'b1;
      end
      default: ctl_d = '0;
    endcase
  end

  // funct is valid from DECODE onward, which is when EXECUTE's code is built.
  always_comb begin
    alucontrol_d = 3'b010;
    case (ctl_d.aluop)
      2'b01:   alucontrol_d = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol_d = 3'b110;
          6'b100100: alucontrol_d = 3'b000;
          6'b100101: alucontrol_d = 3'b001;
          6'b101010: alucontrol_d = 3'b111;
          default:   alucontrol_d = 3'b010;
        endcase
      end
      default: alucontrol_d = 3'b010;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= FETCH;
      run_q        <= 1'b0;
      ctl_q        <= '0;
      alucontrol_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      ctl_q        <= ctl_d;
      alucontrol_q <= alucontrol_d;
    end
  end

  assign pcen       = ctl_q.pcwrite | (ctl_q.branch & zero);
  assign memwrite   = ctl_q.memwrite;
  assign iord       = ctl_q.iord;
  assign irwrite    = ctl_q.irwrite;
  assign regdst     = ctl_q.regdst;
  assign memtoreg   = ctl_q.memtoreg;
  assign regwrite   = ctl_q.regwrite;
  assign alusrca    = ctl_q.alusrca;
  assign alusrcb    = ctl_q.alusrcb;
  assign pcsrc      = ctl_q.pcsrc;
  assign alucontrol = alucontrol_q;
  assign state      = state_q;
  // op only becomes valid once the IR is loaded at the end of FETCH, so this
  // flag must follow op combinationally while in DECODE.
  assign illegal    = (state_q == DECODE) & ~op_legal;

endmodule
